// File: rtl/rtu_req_arbiter.sv
// Round-robin arbiter sharing one RTU lookup engine between the endpoint ports.
// One request in flight at a time; a watchdog forces a dropped response if the engine hangs.
module rtu_req_arbiter #(
    parameter int g_num_ports = 18,
    parameter int g_req_width = 112,
    parameter int g_rsp_width = 32,
    parameter int g_timeout   = 1023
) (
    input  logic                               clk_sys_i,
    input  logic                               rst_i,
    input  logic [g_num_ports-1:0]             port_en_i,
    input  logic [g_num_ports-1:0]             req_i,
    input  logic [g_num_ports*g_req_width-1:0] req_data_i,
    output logic [g_num_ports-1:0]             req_ack_o,
    output logic [g_num_ports-1:0]             rsp_valid_o,
    output logic [g_rsp_width-1:0]             rsp_data_o,
    output logic                               rsp_timeout_o,
    output logic                               eng_req_o,
    output logic [g_req_width-1:0]             eng_data_o,
    input  logic                               eng_ready_i,
    input  logic                               eng_done_i,
    input  logic [g_rsp_width-1:0]             eng_rsp_i,
    output logic                               eng_abort_o,
    output logic                               busy_o
);

    localparam int PW  = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
    localparam int WDW = $clog2(g_timeout + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t                 state_reg, state_next;
    logic [PW-1:0]          ptr_reg, ptr_next;
    logic [PW-1:0]          idx_reg, idx_next;
    logic [WDW-1:0]         wd_reg, wd_next, wd_inc;
    logic [g_req_width-1:0] data_reg, data_next;
    logic [g_rsp_width-1:0] rsp_reg, rsp_next;
    logic                   timeout_reg, timeout_next;

    logic [g_num_ports-1:0] pend;
    logic [PW-1:0]          sel_idx;
    logic                   sel_found;
    logic                   grant;
    logic                   wd_expire;
    logic [g_req_width-1:0] req_words [g_num_ports];

    assign pend      = req_i & port_en_i;
    assign wd_expire = (wd_reg == WDW'(g_timeout - 1));
    assign wd_inc    = (wd_reg == WDW'(g_timeout)) ? wd_reg : wd_reg + 1'b1;
    assign grant     = (state_reg == ST_IDLE) && sel_found && !rst_i;

    // Scan from the farthest offset down so the nearest port after the pointer wins.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = g_num_ports; i >= 1; i--) begin
            cand = int'(ptr_reg) + i;
            if (cand >= g_num_ports) cand = cand - g_num_ports;
            if (pend[PW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(cand);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < g_num_ports; gi++) begin : g_port
            assign req_words[gi]   = req_data_i[gi*g_req_width +: g_req_width];
            assign req_ack_o[gi]   = grant && (sel_idx == PW'(gi));
            assign rsp_valid_o[gi] = (state_reg == ST_RESP) && (idx_reg == PW'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        idx_next     = idx_reg;
        wd_next      = wd_reg;
        data_next    = data_reg;
        rsp_next     = rsp_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                wd_next = '0;
                if (sel_found) begin
                    ptr_next     = sel_idx;
                    idx_next     = sel_idx;
                    data_next    = req_words[sel_idx];
                    timeout_next = 1'b0;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (eng_ready_i) begin
                    wd_next    = '0;
                    state_next = ST_WAIT;
                end else if (wd_expire) begin
                    wd_next      = wd_inc;
                    rsp_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = ST_RESP;
                end else begin
                    wd_next = wd_inc;
                end
            end
            ST_WAIT: begin
                wd_next = wd_inc;
                // A completion arriving in the expiry cycle still counts as a real result.
                if (eng_done_i) begin
                    rsp_next     = eng_rsp_i;
                    timeout_next = 1'b0;
                    state_next   = ST_RESP;
                end else if (wd_expire) begin
                    rsp_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= PW'(g_num_ports - 1);
            idx_reg     <= '0;
            wd_reg      <= '0;
            data_reg    <= '0;
            rsp_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            idx_reg     <= idx_next;
            wd_reg      <= wd_next;
            data_reg    <= data_next;
            rsp_reg     <= rsp_next;
            timeout_reg <= timeout_next;
        end
    end

    assign eng_req_o     = (state_reg == ST_ISSUE);
    assign eng_data_o    = data_reg;
    assign rsp_data_o    = rsp_reg;
    assign rsp_timeout_o = (state_reg == ST_RESP) && timeout_reg;
    assign eng_abort_o   = (state_reg == ST_RESP) && timeout_reg;
    assign busy_o        = (state_reg != ST_IDLE);

    a_ack_onehot: assert property (@(posedge clk_sys_i) disable iff (rst_i) $onehot0(req_ack_o));
    a_rsp_onehot: assert property (@(posedge clk_sys_i) disable iff (rst_i) $onehot0(rsp_valid_o));

endmodule

// File: tb/tb_rtu_req_arbiter.sv
// Bench for rtu_req_arbiter: directed scenarios plus random traffic against a round-robin model.
module tb_rtu_req_arbiter;

    localparam int N  = 18;
    localparam int RW = 112;
    localparam int SW = 32;
    localparam int TO = 16;
    localparam logic [N-1:0] ONE = 1;

    logic              clk_sys_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      port_en_i;
    logic [N-1:0]      req_i;
    logic [N*RW-1:0]   req_data_i;
    logic [N-1:0]      req_ack_o;
    logic [N-1:0]      rsp_valid_o;
    logic [SW-1:0]     rsp_data_o;
    logic              rsp_timeout_o;
    logic              eng_req_o;
    logic [RW-1:0]     eng_data_o;
    logic              eng_ready_i;
    logic              eng_done_i;
    logic [SW-1:0]     eng_rsp_i;
    logic              eng_abort_o;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0] words [N];
    logic [N-1:0]  t_ack, t_rspv;
    logic          t_rq_ack, t_rq_iss, t_to;
    logic [RW-1:0] t_data;
    logic [SW-1:0] t_rsp;
    int            t_ab, t_abc, t_rc;
    bit            t_ok;

    rtu_req_arbiter #(
        .g_num_ports(N), .g_req_width(RW), .g_rsp_width(SW), .g_timeout(TO)
    ) dut (
        .clk_sys_i(clk_sys_i), .rst_i(rst_i), .port_en_i(port_en_i), .req_i(req_i),
        .req_data_i(req_data_i), .req_ack_o(req_ack_o), .rsp_valid_o(rsp_valid_o),
        .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o), .eng_req_o(eng_req_o),
        .eng_data_o(eng_data_o), .eng_ready_i(eng_ready_i), .eng_done_i(eng_done_i),
        .eng_rsp_i(eng_rsp_i), .eng_abort_o(eng_abort_o), .busy_o(busy_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t want < 300000", $time);
        $fatal(1, "time limit");
    end

    // Round-robin reference: first eligible port strictly after the last grant, modulo N.
    function automatic int rr_next(input int last, input logic [N-1:0] pend);
        int order [$];
        for (int i = 1; i <= N; i++) order.push_back((last + i) % N);
        foreach (order[j]) if (pend[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic set_word(input int p, input logic [RW-1:0] w);
        words[p] = w;
        req_data_i[p*RW +: RW] = w;
    endtask

    task automatic rand_word(input int p);
        logic [127:0] tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom};
        set_word(p, tmp[RW-1:0]);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_sys_i);
        #1 rst_i = 1'b0;
    endtask

    // Plays requester and engine for one transaction; returns observations only.
    task automatic run_txn(input int rdy_dly, input int done_dly, input bit hang,
                           input logic [SW-1:0] rsp, input bit keep_req,
                           output logic [N-1:0] ack_vec, output logic rq_at_ack,
                           output logic rq_issue, output logic [RW-1:0] data_seen,
                           output logic [N-1:0] rsp_vec, output logic [SW-1:0] rsp_seen,
                           output logic to_seen, output int aborts, output int abort_cyc,
                           output int rsp_cyc, output bit ok);
        ok = 0; ack_vec = '0; rq_at_ack = 1'b0; rq_issue = 1'b0; data_seen = '0;
        rsp_vec = '0; rsp_seen = '0; to_seen = 1'b0; aborts = 0; abort_cyc = -1; rsp_cyc = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_sys_i);
            if (req_ack_o != '0) begin
                ack_vec = req_ack_o;
                rq_at_ack = eng_req_o;
                break;
            end
            @(posedge clk_sys_i); #1;
        end
        if (ack_vec == '0) return;
        @(posedge clk_sys_i); #1;
        if (!keep_req) req_i = req_i & ~ack_vec;
        for (int c = 0; c <= rdy_dly; c++) begin
            eng_ready_i = (c == rdy_dly);
            @(negedge clk_sys_i);
            if (c == 0) begin
                rq_issue = eng_req_o;
                data_seen = eng_data_o;
            end
            @(posedge clk_sys_i); #1;
        end
        eng_ready_i = 1'b0;
        for (int w = 0; w < 200; w++) begin
            eng_done_i = !hang && (w == done_dly);
            eng_rsp_i  = eng_done_i ? rsp : SW'($urandom);
            @(negedge clk_sys_i);
            if (eng_abort_o) begin
                aborts++;
                abort_cyc = w;
            end
            if (rsp_valid_o != '0) begin
                rsp_vec = rsp_valid_o; rsp_seen = rsp_data_o; to_seen = rsp_timeout_o;
                rsp_cyc = w; ok = 1;
                break;
            end
            @(posedge clk_sys_i); #1;
        end
        eng_done_i = 1'b0;
        @(posedge clk_sys_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; port_en_i = '1; req_i = '0; req_data_i = '0;
        eng_ready_i = 1'b0; eng_done_i = 1'b0; eng_rsp_i = '0;
        for (int p = 0; p < N; p++) set_word(p, '0);
        req_i[4] = 1'b1;
        @(negedge clk_sys_i);
        n_checks++; if (req_ack_o !== '0) begin n_fail++; $display("FAIL reset_ack: got %h want 0", req_ack_o); end
        n_checks++;
        if ({rsp_valid_o, rsp_data_o, rsp_timeout_o, eng_req_o, eng_data_o, eng_abort_o, busy_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rspv=%h rsp=%h to=%b ereq=%b edata=%h abort=%b busy=%b want all 0",
                     rsp_valid_o, rsp_data_o, rsp_timeout_o, eng_req_o, eng_data_o, eng_abort_o, busy_o);
        end
        @(posedge clk_sys_i); #1;
        req_i = '0; rst_i = 1'b0;
        @(negedge clk_sys_i);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy_o); end
        @(posedge clk_sys_i); #1;
    endtask

    task automatic test_single();
        set_word(3, 112'h0123_4567_89ab_cdef_0011_2233_4455);
        req_i[3] = 1'b1;
        run_txn(0, 5, 0, 32'h0002_0000, 0, t_ack, t_rq_ack, t_rq_iss, t_data, t_rspv, t_rsp, t_to, t_ab, t_abc, t_rc, t_ok);
        n_checks++; if (!t_ok) begin n_fail++; $display("FAIL single_done: got no response want response"); end
        n_checks++; if (t_ack !== ONE << 3) begin n_fail++; $display("FAIL single_ack: got %h want %h", t_ack, ONE << 3); end
        n_checks++; if (t_rq_ack !== 1'b0) begin n_fail++; $display("FAIL single_ereq_at_ack: got %b want 0", t_rq_ack); end
        n_checks++; if (t_rq_iss !== 1'b1) begin n_fail++; $display("FAIL single_ereq_issue: got %b want 1", t_rq_iss); end
        n_checks++; if (t_data !== words[3]) begin n_fail++; $display("FAIL single_eng_data: got %h want %h", t_data, words[3]); end
        n_checks++; if (t_rspv !== ONE << 3) begin n_fail++; $display("FAIL single_rspv: got %h want %h", t_rspv, ONE << 3); end
        n_checks++; if (t_rsp !== 32'h0002_0000) begin n_fail++; $display("FAIL single_rsp: got %h want 00020000", t_rsp); end
        n_checks++; if (t_to !== 1'b0 || t_ab != 0) begin n_fail++; $display("FAIL single_timeout: got to=%b aborts=%0d want 0/0", t_to, t_ab); end
        n_checks++; if (t_rc != 6) begin n_fail++; $display("FAIL single_latency: got rsp at wait cycle %0d want 6", t_rc); end
        $display("single: ack=%h rsp=%h cyc=%0d", t_ack, t_rsp, t_rc);
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 17, 0, 1, 17};
        do_reset();
        rand_word(0); rand_word(1); rand_word(17);
        req_i = (ONE << 0) | (ONE << 1) | (ONE << 17);
        for (int i = 0; i < 6; i++) begin
            logic [SW-1:0] r;
            r = $urandom;
            run_txn(0, 1, 0, r, 1, t_ack, t_rq_ack, t_rq_iss, t_data, t_rspv, t_rsp, t_to, t_ab, t_abc, t_rc, t_ok);
            n_checks++;
            if (t_ack !== ONE << order[i]) begin n_fail++; $display("FAIL rr_grant%0d: got %h want %h", i, t_ack, ONE << order[i]); end
            n_checks++;
            if (t_rsp !== r || t_rspv !== ONE << order[i]) begin
                n_fail++; $display("FAIL rr_rsp%0d: got %h/%h want %h/%h", i, t_rspv, t_rsp, ONE << order[i], r);
            end
            $display("rr txn %0d: ack=%h rsp=%h", i, t_ack, t_rsp);
        end
        req_i = '0;
    endtask

    task automatic test_enable_mask();
        int acks;
        port_en_i = ~(ONE << 5);
        rand_word(5); rand_word(6);
        req_i = (ONE << 5) | (ONE << 6);
        run_txn(1, 2, 0, 32'h0000_0040, 0, t_ack, t_rq_ack, t_rq_iss, t_data, t_rspv, t_rsp, t_to, t_ab, t_abc, t_rc, t_ok);
        n_checks++; if (t_ack !== ONE << 6) begin n_fail++; $display("FAIL mask_grant6: got %h want %h", t_ack, ONE << 6); end
        n_checks++; if (t_data !== words[6]) begin n_fail++; $display("FAIL mask_data6: got %h want %h", t_data, words[6]); end
        acks = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_sys_i);
            if (req_ack_o != '0 || busy_o) acks++;
            @(posedge clk_sys_i); #1;
        end
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL mask_port5: got %0d active cycles want 0", acks); end
        $display("mask: ack=%h masked_port_active=%0d", t_ack, acks);
        req_i = '0; port_en_i = '1;
    endtask

    task automatic test_watchdog();
        rand_word(7);
        req_i[7] = 1'b1;
        run_txn(0, 0, 1, '0, 0, t_ack, t_rq_ack, t_rq_iss, t_data, t_rspv, t_rsp, t_to, t_ab, t_abc, t_rc, t_ok);
        n_checks++; if (!t_ok || t_rspv !== ONE << 7) begin n_fail++; $display("FAIL wd_rspv: got %h want %h", t_rspv, ONE << 7); end
        n_checks++; if (t_rc != TO) begin n_fail++; $display("FAIL wd_cycle: got %0d want %0d", t_rc, TO); end
        n_checks++; if (t_rsp !== '0 || t_to !== 1'b1) begin n_fail++; $display("FAIL wd_rsp: got %h/to=%b want 0/1", t_rsp, t_to); end
        n_checks++; if (t_ab != 1 || t_abc != TO) begin n_fail++; $display("FAIL wd_abort: got %0d pulses at %0d want 1 at %0d", t_ab, t_abc, TO); end
        $display("watchdog: rsp=%h to=%b abort_cyc=%0d", t_rsp, t_to, t_abc);
        rand_word(2);
        req_i[2] = 1'b1;
        run_txn(0, 3, 0, 32'hdead_0004, 0, t_ack, t_rq_ack, t_rq_iss, t_data, t_rspv, t_rsp, t_to, t_ab, t_abc, t_rc, t_ok);
        n_checks++;
        if (t_ack !== ONE << 2 || t_rsp !== 32'hdead_0004 || t_to !== 1'b0 || t_ab != 0 || t_rc != 4) begin
            n_fail++; $display("FAIL wd_recover: got ack=%h rsp=%h to=%b ab=%0d cyc=%0d want %h dead0004 0 0 4",
                                t_ack, t_rsp, t_to, t_ab, t_rc, ONE << 2);
        end
        $display("post-watchdog: ack=%h rsp=%h", t_ack, t_rsp);
    endtask

    task automatic test_collision();
        int late_bad;
        rand_word(11);
        req_i[11] = 1'b1;
        run_txn(0, TO - 1, 0, 32'h1234_5678, 0, t_ack, t_rq_ack, t_rq_iss, t_data, t_rspv, t_rsp, t_to, t_ab, t_abc, t_rc, t_ok);
        n_checks++; if (t_rsp !== 32'h1234_5678 || t_rc != TO) begin n_fail++; $display("FAIL coll_rsp: got %h at %0d want 12345678 at %0d", t_rsp, t_rc, TO); end
        n_checks++; if (t_to !== 1'b0 || t_ab != 0) begin n_fail++; $display("FAIL coll_abort: got to=%b aborts=%0d want 0/0", t_to, t_ab); end
        $display("collision: rsp=%h to=%b aborts=%0d", t_rsp, t_to, t_ab);
        late_bad = 0;
        eng_done_i = 1'b1; eng_rsp_i = 32'hffff_ffff;
        @(negedge clk_sys_i);
        if (busy_o || rsp_valid_o != '0) late_bad++;
        @(posedge clk_sys_i); #1;
        eng_done_i = 1'b0;
        @(negedge clk_sys_i);
        if (busy_o || rsp_valid_o != '0) late_bad++;
        n_checks++; if (late_bad != 0) begin n_fail++; $display("FAIL late_done: got %0d active cycles want 0", late_bad); end
        @(posedge clk_sys_i); #1;
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0] seen;
        rand_word(0); rand_word(9);
        do_reset();
        req_i = (ONE << 0) | (ONE << 9);
        seen = '0;
        for (int c = 0; c < 20 && seen == '0; c++) begin
            @(negedge clk_sys_i); seen = req_ack_o;
            @(posedge clk_sys_i); #1;
        end
        n_checks++; if (seen !== ONE) begin n_fail++; $display("FAIL rstw_first_grant: got %h want %h", seen, ONE); end
        eng_ready_i = 1'b1;
        @(posedge clk_sys_i); #1;
        eng_ready_i = 1'b0;
        @(posedge clk_sys_i); #1;
        @(negedge clk_sys_i);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rstw_busy: got %b want 1", busy_o); end
        #1 rst_i = 1'b1;
        #1;
        n_checks++;
        if ({req_ack_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, eng_req_o, eng_data_o, eng_abort_o, busy_o} !== '0) begin
            n_fail++; $display("FAIL rstw_outputs: got ack=%h busy=%b edata=%h want all 0", req_ack_o, busy_o, eng_data_o);
        end
        @(posedge clk_sys_i); #1;
        rst_i = 1'b0;
        @(negedge clk_sys_i);
        n_checks++; if (req_ack_o !== ONE) begin n_fail++; $display("FAIL rstw_regrant: got %h want %h", req_ack_o, ONE); end
        $display("reset mid-wait: regrant=%h", req_ack_o);
        @(posedge clk_sys_i); #1;
        req_i = '0;
        do_reset();
    endtask

    task automatic test_random();
        int last, expv, rdy, dd;
        logic [SW-1:0] r;
        do_reset();
        last = N - 1;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_i[p] && $urandom_range(0, 3) == 0) begin
                    rand_word(p);
                    req_i[p] = 1'b1;
                end
            end
            port_en_i = ($urandom_range(0, 2) == 0) ? ~(ONE << $urandom_range(0, N - 1)) : '1;
            if ((req_i & port_en_i) == '0) begin
                for (int p = 0; p < N; p++) begin
                    if (port_en_i[p] && (req_i & port_en_i) == '0) begin
                        rand_word(p);
                        req_i[p] = 1'b1;
                    end
                end
            end
            expv = rr_next(last, req_i & port_en_i);
            last = expv;
            r = $urandom; rdy = $urandom_range(0, 3); dd = $urandom_range(0, 6);
            run_txn(rdy, dd, 0, r, 0, t_ack, t_rq_ack, t_rq_iss, t_data, t_rspv, t_rsp, t_to, t_ab, t_abc, t_rc, t_ok);
            n_checks++;
            if (t_ack !== ONE << expv || t_data !== words[expv]) begin
                n_fail++; $display("FAIL rand%0d_grant: got %h data %h want %h data %h", it, t_ack, t_data, ONE << expv, words[expv]);
            end
            n_checks++;
            if (!t_ok || t_rspv !== ONE << expv || t_rsp !== r || t_to !== 1'b0 || t_ab != 0 || t_rc != dd + 1) begin
                n_fail++; $display("FAIL rand%0d_rsp: got %h/%h to=%b ab=%0d cyc=%0d want %h/%h 0 0 %0d",
                                   it, t_rspv, t_rsp, t_to, t_ab, t_rc, ONE << expv, r, dd + 1);
            end
            $display("rand txn %0d: port=%0d ack=%h rsp=%h", it, expv, t_ack, t_rsp);
        end
        req_i = '0; port_en_i = '1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_enable_mask();
        test_watchdog();
        test_collision();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtu_req_arbiter.md
Name: rtu_req_arbiter

Overview:
- Shares the single RTU lookup engine between the g_num_ports endpoint requesters using round-robin.
- Latches one request at a time, drives the engine with a valid/ready handshake, and waits for the engine's completion.
- Returns the result to the granted port; a hung engine is recovered by a watchdog.
- Sits between the endpoint RX paths and the RTU match core in the switch core; the per-port enable mask comes from the RTU port-config registers.

Parameters:
- g_num_ports, 18, number of requesting ports (1..32).
- g_req_width, 112, width of one request word (DMAC, SMAC, VID, PRIO, flags).
- g_rsp_width, 32, width of one response word (destination port mask).
- g_timeout, 1023, engine watchdog in clk_sys_i cycles (>=2).

Ports:
- clk_sys_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- port_en_i  in  g_num_ports  per-port enable; a 0 bit masks that port's request.
- req_i  in  g_num_ports  per-port request, held high until acked.
- req_data_i  in  g_num_ports*g_req_width  flattened request words; port k occupies bits [k*g_req_width +: g_req_width].
- req_ack_o  out  g_num_ports  one-cycle one-hot grant; the request data is captured in that cycle.
- rsp_valid_o  out  g_num_ports  one-cycle one-hot response strobe.
- rsp_data_o  out  g_rsp_width  response word, valid while any rsp_valid_o bit is high.
- rsp_timeout_o  out  1  high together with rsp_valid_o when the response was forced by the watchdog.
- eng_req_o  out  1  request valid to the engine.
- eng_data_o  out  g_req_width  latched request word.
- eng_ready_i  in  1  engine accepts the request when eng_req_o & eng_ready_i.
- eng_done_i  in  1  one-cycle engine completion.
- eng_rsp_i  in  g_rsp_width  engine result, valid with eng_done_i.
- eng_abort_o  out  1  one-cycle pulse on watchdog expiry; resets the engine's match FSM.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state): all outputs 0; FSM to IDLE; watchdog counter 0; last-grant pointer = g_num_ports-1, so port 0 has first priority.
- Eligible ports: pend = req_i & port_en_i.
- IDLE:
  - If pend != 0, select the first set bit strictly after the last-grant pointer, wrapping modulo g_num_ports.
  - In the same cycle: assert req_ack_o[k]; latch port index k and req_data_i slice k into eng_data_o; pointer <= k; go to ISSUE.
  - If pend == 0: stay in IDLE, outputs 0.
- ISSUE:
  - eng_req_o=1 with eng_data_o held stable.
  - On eng_ready_i=1: eng_req_o deasserts next cycle; go to WAIT; watchdog cleared.
  - The watchdog also counts in ISSUE (an engine stuck not-ready is recovered the same way).
- WAIT:
  - Watchdog increments each cycle.
  - On eng_done_i: capture eng_rsp_i; go to RESP.
  - Else, when the watchdog reaches g_timeout: response word <= 0 (drop), set timeout flag, pulse eng_abort_o for one cycle, go to RESP.
  - eng_done_i in the same cycle as expiry: done wins, no abort, flag clear.
- RESP:
  - rsp_valid_o[k]=1 for exactly one cycle, with rsp_data_o and rsp_timeout_o.
  - Next state is IDLE; the next grant is evaluated in the IDLE cycle, so there is a minimum of 1 idle cycle between a response and the next ack.
- Best-case latency: req_i rise to req_ack_o is 1 cycle from IDLE. Ack to eng_req_o is 1 cycle. eng_done_i to rsp_valid_o is 1 cycle.
- Late done: eng_done_i outside WAIT is ignored.
- Enable change mid-transaction: port_en_i changing after grant does not abort the transaction; the enable mask affects arbitration only.
- Requester obligations: req_i must stay high until ack; deasserting before ack withdraws the request with no side effects. A requester may re-raise req_i immediately after its ack; it is served again only after all other pending enabled ports (fairness).
- Single eligible port: re-grants the same port back-to-back.
- Width rules: watchdog counter is clog2(g_timeout+1) bits and saturates at g_timeout; the pointer is clog2(g_num_ports) bits.
- Assertions: at most one req_ack_o bit and at most one rsp_valid_o bit set per cycle.

Test Plan:
- Single request: port 3 req with data D, engine ready immediately, done after 5 cycles with 0x00020000 -> req_ack_o=1<<3 one cycle; eng_data_o=D; rsp_valid_o=1<<3 with rsp_data_o=0x00020000, rsp_timeout_o=0.
- Round-robin: ports 0, 1 and 17 all requesting continuously, engine done 2 cycles after accept -> grant order 0,1,17,0,1,17; no port granted twice before the others are served.
- Enable mask: port_en_i bit 5 = 0, port 5 requesting -> no ack to port 5 ever; port 6 requesting -> served normally.
- Watchdog: g_timeout=16, engine never asserts done -> eng_abort_o pulse 16 cycles after accept; rsp_valid_o with rsp_data_o=0, rsp_timeout_o=1; next request then proceeds normally.
- Collision: eng_done_i in the expiry cycle -> engine data returned, rsp_timeout_o=0, no eng_abort_o.
- Reset mid-WAIT: rst_i pulsed -> all outputs 0 immediately; after release the first grant goes to the lowest pending port (port 0 if requesting).
